// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - op encoding, FSM states and shared constants for the load/store unit
package lsu_pkg;

  typedef enum logic [2:0] {
    LW  = 3'b000,
    LH  = 3'b001,
    LHU = 3'b010,
    LB  = 3'b011,
    LBU = 3'b100,
    SW  = 3'b101,
    SH  = 3'b110,
    SB  = 3'b111
  } lsu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CAP,
    WR
  } lsu_state_e;

  localparam int WORD_BYTES = 4;
  localparam int MEM_AW     = 10;

  function automatic logic misaligned(input lsu_op_e o, input logic [1:0] lo);
    case (o)
      LW, SW:      misaligned = (lo != 2'b00);
      LH, LHU, SH: misaligned = lo[0];
      default:     misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte/halfword lane extract+extend for loads and lane merge for stores
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter bit BIG_END = 1'b0
) (
  input  lsu_op_e     op,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [1:0]  bidx;
  logic        hidx;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    // Big-endian puts byte 0 in the most significant lane.
    bidx = BIG_END ? ~lane : lane;
    hidx = BIG_END ? ~lane[1] : lane[1];
    b    = old_word[8*bidx +: 8];
    h    = old_word[16*hidx +: 16];

    case (op)
      LH:      load_val = {{16{h[15]}}, h};
      LHU:     load_val = {16'h0000, h};
      LB:      load_val = {{24{b[7]}}, b};
      LBU:     load_val = {24'h000000, b};
      default: load_val = old_word;
    endcase

    store_word = old_word;
    case (op)
      SB:      store_word[8*bidx +: 8]   = wdata[7:0];
      SH:      store_word[16*hidx +: 16] = wdata[15:0];
      SW:      store_word                = wdata;
      default: store_word                = old_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-addressed load/store front end for a word-only data memory
// Optional LSU_MISALIGN_CHECK_EN: reject misaligned accesses with done+err, no memory access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter bit BIG_END = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              err,
  output logic [9:0]        mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state;
  lsu_op_e           op_in;
  lsu_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       wr_word;
  logic [ADDR_W-3:0] word_addr;
  logic [31:0]       load_val;
  logic [31:0]       store_word;
  logic              misal;

  assign op_in = lsu_op_e'(op);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misal = misaligned(op_in, addr[1:0]);
`else
  assign misal = 1'b0;
`endif

  assign ready     = (state == IDLE);
  assign word_addr = addr_q[ADDR_W-1:2];
  assign mem_addr  = MEM_AW'(word_addr);
  assign mem_wdata = wr_word;
  // Reset in the WR cycle must not let a half-finished RMW reach memory.
  assign mem_we    = (state == WR) & ~rst;

  lsu_lane_align #(
    .BIG_END(BIG_END)
  ) u_align (
    .op        (op_q),
    .lane      (addr_q[1:0]),
    .old_word  (mem_rdata),
    .wdata     (wdata_q),
    .load_val  (load_val),
    .store_word(store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      err       <= 1'b0;
      load_data <= '0;
      op_q      <= LW;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_word   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            op_q    <= op_in;
            addr_q  <= addr;
            wdata_q <= wdata;
            wr_word <= wdata;
            if (misal) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else if (op_in == SW) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: state <= CAP;
        CAP: begin
          if (op_q == SH || op_q == SB) begin
            wr_word <= store_word;
            state   <= WR;
          end else begin
            load_data <= load_val;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        WR: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [2:0]  op;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] load_data;
  logic        err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic        tb_we;
  logic [9:0]  tb_waddr;
  logic [31:0] tb_wdata;
  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  int          done_cyc, done_cnt, we_cnt, we_cyc;
  logic [31:0] we_data;
  logic        err_at_done;
  logic [31:0] prev;

  load_store_unit dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .op       (op),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .done     (done),
    .load_data(load_data),
    .err      (err),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory with registered read; the bench-side port only preloads.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_waddr] <= tb_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; op = o; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  // k counts cycles after the accepting edge, so k=1 is cycle T+1.
  task automatic watch(input bit busy);
    done_cyc = 0; done_cnt = 0; we_cnt = 0; we_cyc = 0; we_data = '0; err_at_done = 1'b0;
    if (busy) begin
      req = 1'b1; op = SW; addr = 12'h400; wdata = 32'h0;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc    = k;
          err_at_done = err;
        end
      end
      if (mem_we) begin
        we_cnt++;
        we_cyc  = k;
        we_data = mem_wdata;
      end
      if (k == 2) req = 1'b0;
    end
  endtask

  task automatic do_load(input string tag, input logic [2:0] o, input logic [11:0] a,
                         input logic [31:0] exp, input bit busy);
    issue(o, a, 32'h0);
    watch(busy);
    check({tag, "_data"}, load_data, exp);
    check({tag, "_lat"}, done_cyc, 3);
    check({tag, "_pulse"}, done_cnt, 1);
    check({tag, "_nowe"}, we_cnt, 0);
    check({tag, "_err"}, err_at_done, 1'b0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] o, input logic [11:0] a,
                          input logic [31:0] d, input int lat, input logic [31:0] exp_word);
    issue(o, a, d);
    watch(1'b0);
    check({tag, "_lat"}, done_cyc, lat);
    check({tag, "_pulse"}, done_cnt, 1);
    check({tag, "_wecnt"}, we_cnt, 1);
    check({tag, "_wecyc"}, we_cyc, lat - 1);
    check({tag, "_wdata"}, we_data, exp_word);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; op = 3'b000; addr = '0; wdata = '0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    @(negedge clk);
    tb_we = 1'b1; tb_waddr = 10'd256; tb_wdata = 32'h0000_07D1;
    @(negedge clk);
    tb_waddr = 10'd257; tb_wdata = 32'h0000_0FA1;
    @(negedge clk);
    tb_we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_mem_we", mem_we, 1'b0);

    do_load("lb_400", LB, 12'h400, 32'hFFFF_FFD1, 1'b0);
    do_load("lbu_400", LBU, 12'h400, 32'h0000_00D1, 1'b0);
    do_load("lh_400", LH, 12'h400, 32'h0000_07D1, 1'b0);
    do_load("lw_404", LW, 12'h404, 32'h0000_0FA1, 1'b1);

    do_store("sb_401", SB, 12'h401, 32'h1234_56AA, 4, 32'h0000_AAD1);
    do_load("lw_400", LW, 12'h400, 32'h0000_AAD1, 1'b0);

    do_store("sw_408", SW, 12'h408, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);
    do_store("sh_40a", SH, 12'h40A, 32'h0000_5555, 4, 32'h5555_BEEF);
    do_load("lw_408", LW, 12'h408, 32'h5555_BEEF, 1'b0);
    do_load("lh_408", LH, 12'h408, 32'hFFFF_BEEF, 1'b0);
    do_load("lhu_408", LHU, 12'h408, 32'h0000_BEEF, 1'b0);
    do_load("lb_40b", LB, 12'h40B, 32'h0000_0055, 1'b0);

    // Reset lands in the WR cycle of an SB; the write must be dropped.
    issue(SB, 12'h400, 32'h0000_00FF);
    @(posedge clk);
    @(posedge clk);
    #1 check("rmw_in_wr", ready, 1'b0);
    rst = 1'b1;
    #1 check("rst_wr_we", mem_we, 1'b0);
    check("rst_wr_done", done, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_wr_ready", ready, 1'b1);
    check("rst_wr_done2", done, 1'b0);
    do_load("lw_after_rst", LW, 12'h400, 32'h0000_AAD1, 1'b0);

`ifdef LSU_MISALIGN_CHECK_EN
    prev = load_data;
    issue(LW, 12'h402, 32'h0);
    @(negedge clk);
    check("mis_done", done, 1'b1);
    check("mis_err", err, 1'b1);
    check("mis_we", mem_we, 1'b0);
    check("mis_hold", load_data, prev);
    req = 1'b1; op = LW; addr = 12'h404;
    @(posedge clk);
    #1 req = 1'b0;
    watch(1'b0);
    check("b2b_lat", done_cyc, 3);
    check("b2b_data", load_data, 32'h0000_0FA1);
    check("b2b_err", err_at_done, 1'b0);
`else
    do_load("lw_402_forced", LW, 12'h402, 32'h0000_AAD1, 1'b0);
    do_load("lh_401_forced", LHU, 12'h401, 32'h0000_AAD1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the CPU memory-stage and the word-only data memory: clk, 10-bit word address, 32-bit data_in, we, registered data_out with 1-cycle read latency.
- Translates CPU byte-addressed LW/LH/LHU/LB/LBU/SW/SH/SB requests into word accesses.
- Loads: sign- or zero-extends the selected byte or halfword.
- Sub-word stores: read-modify-write.
- CPU-side interface is a req/ready handshake with a done pulse.

Parameters:
ADDR_W, 12, CPU byte-address width; mem_addr = addr[11:2].
BIG_END, 0, byte-lane order: 0 = little-endian (byte 0 = bits 7:0); 1 = big-endian.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
req  in  1  request valid; accepted only when ready=1
op  in  3  operation code (package encoding)
addr  in  ADDR_W  byte address
wdata  in  32  store data (SB uses [7:0], SH uses [15:0])
ready  out  1  combinational, =1 iff state==IDLE
done  out  1  registered one-cycle completion pulse
load_data  out  32  registered extended load result, held until next load done
err  out  1  registered misalignment flag, valid with done
mem_addr  out  10  word address to data memory
mem_wdata  out  32  write data to data memory
mem_we  out  1  write enable to data memory
mem_rdata  in  32  data-memory registered read data

Behaviour:
- Reset (sync): state=IDLE; done=0, err=0, load_data=0; latched op/addr/wdata cleared.
- mem_we = (state==WR) & ~rst: reset asserted in a WR cycle suppresses the write, and any in-flight RMW is aborted.
- Accept: req & ready at edge T latches op, addr, wdata. req while busy is ignored and not queued.
- Memory drive: mem_addr driven from the latched addr[ADDR_W-1:2] in every non-IDLE state; mem_we=0 outside WR.
- States: IDLE, RD (read issued), CAP (mem_rdata valid), WR (write issued).
- LW/LH/LHU/LB/LBU: IDLE(T) -> RD(T+1) -> CAP(T+2), where the lane is extracted and extended into load_data -> IDLE. done=1 and load_data valid in cycle T+3.
- SW: IDLE(T) -> WR(T+1), mem_wdata=wdata -> IDLE; done=1 in T+2.
- SH/SB: IDLE(T) -> RD(T+1) -> CAP(T+2), merged word registered -> WR(T+3) -> IDLE; done=1 in T+4.
- Lane selection: byte uses addr[1:0], halfword uses addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- done pulses exactly one cycle. A new req may be accepted in the same cycle done=1, since state is IDLE.
- No address range check: the data memory's base offset is handled downstream, and out-of-range addresses wrap there.
- err=0 whenever the optional feature is absent.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined:
  - LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]=1: no memory access (RD/WR not entered).
  - done=1 and err=1 in T+1; load_data unchanged.
- Undefined:
  - Low address bits below the access size are ignored (forced aligned).
  - err tied to 0.

Decomposition:
- Package lsu_pkg:
  - op encoding: LW=3'b000, LH=001, LHU=010, LB=011, LBU=100, SW=101, SH=110, SB=111
  - state enum
  - helper constants WORD_BYTES=4, MEM_AW=10
- Sub-module lsu_lane_align (combinational) takes op, addr[1:0], old word and wdata, and returns:
  - the extracted/extended load value
  - the merged store word
- load_store_unit keeps the FSM and registers.

Test Plan:
- Memory word 256 preset 0x000007D1. LB at byte addr 0x400 -> load_data=0xFFFFFFD1, done in T+3. LBU at 0x400 -> 0x000000D1.
- LH at 0x400 -> 0x000007D1. LW at 0x404 (word 257 = 0x00000FA1) -> 0x00000FA1, mem_we never 1.
- SB wdata=0x123456AA at 0x401 -> one mem_we pulse in T+3 with mem_wdata=0x0000AAD1, done in T+4. Following LW 0x400 -> 0x0000AAD1.
- SW 0xDEADBEEF at 0x408: mem_we=1 only in T+1, done in T+2. Then SH 0x5555 at 0x40A -> LW 0x408 returns 0x5555BEEF.
- rst asserted during the WR cycle of an SB at 0x400 -> mem_we=0, state=IDLE, done=0. LW 0x400 then returns the pre-store value.
- With LSU_MISALIGN_CHECK_EN: LW at 0x402 -> done=1, err=1 in T+1, mem_we=0, load_data unchanged. Back-to-back req in the done cycle is accepted.
